// File: rtl/fp_lets_if.sv
// Operand/result bundle for the fp_lets fixed-point arithmetic unit.
// The master drives operands and receives results; the slave is the unit itself.
interface fp_lets_if;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic [31:0] c;
   logic        out_valid;
   logic [31:0] s0;
   logic [31:0] s1;
   logic [31:0] s2;
   logic [31:0] p0;
   logic [31:0] p1;
   logic [31:0] p2;

   modport master (
      output in_valid, a, b, c,
      input  out_valid, s0, s1, s2, p0, p1, p2
   );

   modport slave (
      input  in_valid, a, b, c,
      output out_valid, s0, s1, s2, p0, p1, p2
   );
endinterface

// File: rtl/fp_lets.sv
// Registered Q1.15 / Q9.23 adder-multiplier: three sums and three products, each
// computed at full precision and floor-truncated to its own output scale, one-cycle latency.
module fp_lets (
   input  logic       clk,
   input  logic       rst,
   fp_lets_if.slave   bus
);

   // Result slots in output order: s0, s1, s2, p0, p1, p2
   typedef logic [5:0][31:0] res_t;

   logic signed [15:0] a_s;
   logic signed [15:0] b_s;
   logic signed [31:0] c_s;

   logic signed [16:0] sum_ab;   // Q2.15, exact
   logic signed [32:0] a_al;     // a aligned to Q10.23
   logic signed [32:0] c_ext;    // c sign-extended to Q10.23
   logic signed [32:0] sum_ac;   // Q10.23, exact
   logic signed [31:0] a_w32;
   logic signed [31:0] b_w32;
   logic signed [31:0] prod_ab;  // Q2.30, exact
   logic signed [47:0] a_w48;
   logic signed [47:0] c_w48;
   logic signed [47:0] prod_ac;  // Q10.38, exact

   res_t res_calc;
   res_t res_d;
   res_t res_q;
   logic valid_d;
   logic valid_q;
   logic unused_prod_bits;

   assign a_s = bus.a;
   assign b_s = bus.b;
   assign c_s = bus.c;

   // Sums carry one extra integer bit so they never saturate or wrap before rescale
   assign sum_ab = {a_s[15], a_s} + {b_s[15], b_s};
   assign a_al   = {{9{a_s[15]}}, a_s, 8'b0};
   assign c_ext  = {c_s[31], c_s};
   assign sum_ac = a_al + c_ext;

   assign a_w32   = {{16{a_s[15]}}, a_s};
   assign b_w32   = {{16{b_s[15]}}, b_s};
   assign prod_ab = a_w32 * b_w32;

   assign a_w48   = {{32{a_s[15]}}, a_s};
   assign c_w48   = {{16{c_s[31]}}, c_s};
   assign prod_ac = a_w48 * c_w48;

   // Rescale by bit selection: dropping low bits of a two's-complement value is floor
   always_comb begin
      res_calc    = '0;
      // s0: Q2.15 at fo=15, no shift
      res_calc[0] = {{15{sum_ab[16]}}, sum_ab};
      // s1: Q10.23 -> fo=15, drop 8 fraction bits
      res_calc[1] = {{7{sum_ac[32]}}, sum_ac[32:8]};
      // s2: Q10.23 at fo=23, 33 bits wrapped to 32
      res_calc[2] = sum_ac[31:0];
      // p0: Q2.30 -> fo=15, drop 15 fraction bits
      res_calc[3] = {{15{prod_ab[31]}}, prod_ab[31:15]};
      // p1: Q2.30 at fo=30, no shift
      res_calc[4] = prod_ab;
      // p2: Q10.38 -> fo=23 is 33 bits; wrap keeps the low 32
      res_calc[5] = prod_ac[46:15];
   end

   assign unused_prod_bits = ^{prod_ac[47], prod_ac[14:0]};

   always_comb begin
      res_d   = res_q;
      valid_d = bus.in_valid;
      if (bus.in_valid) begin
         res_d = res_calc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.s0        = res_q[0];
   assign bus.s1        = res_q[1];
   assign bus.s2        = res_q[2];
   assign bus.p0        = res_q[3];
   assign bus.p1        = res_q[4];
   assign bus.p2        = res_q[5];

endmodule

// File: tb/tb_fp_lets.sv
// Scoreboard bench for fp_lets: a real-valued reference model predicts each result,
// a negedge monitor compares, and checks hold/reset behaviour between transactions.
module tb_fp_lets;

   typedef logic [5:0][31:0] res_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fp_lets_if bus ();

   fp_lets dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   res_t  exp_q[$];
   res_t  last_exp = '0;
   int    checks = 0;
   int    errors = 0;
   bit    started = 1'b0;
   bit    cap_rst;
   bit    cap_v;
   string names[6] = '{"s0", "s1", "s2", "p0", "p1", "p2"};

   // floor(x * 2^fo), wrapped to 32 bits
   function automatic logic [31:0] fix(real x, int fo);
      real    y;
      longint v;
      y = $floor(x * (2.0 ** fo));
      v = longint'(y);
      return v[31:0];
   endfunction

   function automatic res_t model(logic [15:0] a, logic [15:0] b, logic [31:0] c);
      real  ra;
      real  rb;
      real  rc;
      res_t r;
      ra   = real'($signed(a)) / 32768.0;
      rb   = real'($signed(b)) / 32768.0;
      rc   = real'($signed(c)) / 8388608.0;
      r[0] = fix(ra + rb, 15);
      r[1] = fix(ra + rc, 15);
      r[2] = fix(ra + rc, 23);
      r[3] = fix(ra * rb, 15);
      r[4] = fix(ra * rb, 30);
      r[5] = fix(ra * rc, 23);
      return r;
   endfunction

   task automatic check(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h expected %h", n, $time, act, exp);
      end
   endtask

   task automatic drive(bit r, bit v, logic [15:0] a, logic [15:0] b, logic [31:0] c);
      @(posedge clk);
      #1;
      rst          = r;
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.c        = c;
      if (v && !r) exp_q.push_back(model(a, b, c));
   endtask

   task automatic drive_rand(bit r, bit v);
      int ai;
      int bi;
      int ci;
      ai = int'($urandom_range(65534)) - 32767;
      bi = int'($urandom_range(65534)) - 32767;
      ci = int'($urandom_range(16777214)) - 8388607;
      drive(r, v, ai[15:0], bi[15:0], ci[31:0]);
   endtask

   // Capture what the DUT sampled at this edge; inputs change only #1 later
   always @(posedge clk) begin
      cap_rst = rst;
      cap_v   = bus.in_valid;
      started = 1'b1;
   end

   always @(negedge clk) begin
      res_t act;
      if (started) begin
         act = {bus.p2, bus.p1, bus.p0, bus.s2, bus.s1, bus.s0};
         if (cap_rst) begin
            check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            for (int i = 0; i < 6; i++) check({"rst_", names[i]}, act[i], 32'd0);
            last_exp = '0;
         end else if (cap_v) begin
            check("out_valid_high", {31'b0, bus.out_valid}, 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow @%0t: got result with no expectation", $time);
            end else begin
               last_exp = exp_q.pop_front();
               for (int i = 0; i < 6; i++) check(names[i], act[i], last_exp[i]);
            end
         end else begin
            check("out_valid_low", {31'b0, bus.out_valid}, 32'd0);
            for (int i = 0; i < 6; i++) check({"hold_", names[i]}, act[i], last_exp[i]);
         end
      end
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      bus.c        = '0;

      // Reset dominates a simultaneous in_valid
      drive(1, 1, 16'h1234, 16'h5678, 32'h0ABCDEF0);
      drive(1, 1, 16'h7FFF, 16'h7FFF, 32'h00800000);

      // Directed cases, first accepted on the edge after reset deasserts
      drive(0, 1, 16'h4000, 16'h2000, 32'h00800000);
      drive(0, 1, 16'hFFFF, 16'h0001, 32'h00000000);
      drive(0, 1, 16'h0000, 16'h0000, 32'h00000001);
      drive(0, 1, 16'h0000, 16'h0000, 32'hFFFFFFFF);
      drive(0, 1, 16'h7FFF, 16'h7FFF, 32'h7FFFFFFF);
      drive(0, 1, 16'h8000, 16'h8000, 32'h80000000);
      drive(0, 1, 16'h8000, 16'h7FFF, 32'hFF800000);
      drive(0, 1, 16'h7FFF, 16'h8000, 32'h00800000);

      // in_valid 1,0,0,1: outputs hold across the gap
      drive(0, 1, 16'h1357, 16'hE000, 32'hFFC00001);
      drive(0, 0, 16'hAAAA, 16'h5555, 32'h12345678);
      drive(0, 0, 16'h5555, 16'hAAAA, 32'h87654321);
      drive(0, 1, 16'hC000, 16'h4000, 32'h00400000);

      // Random regression with occasional idle cycles
      for (int n = 0; n < 10000; n++) begin
         drive_rand(0, ($urandom_range(99) < 85));
      end

      // Reset mid-stream with valid operands, then resume
      drive_rand(0, 1);
      drive_rand(1, 1);
      drive_rand(0, 0);
      drive_rand(0, 1);
      drive_rand(0, 1);
      for (int n = 0; n < 200; n++) begin
         drive_rand(0, ($urandom_range(99) < 70));
      end

      drive(0, 0, 16'h0000, 16'h0000, 32'h00000000);
      drive(0, 0, 16'h0000, 16'h0000, 32'h00000000);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
